data_memory_ctrl: RTL and testbench
===================================

// Module: data_memory_ctrl
// PURPOSE
//  Data memory with BUSYWAIT handshake; the responder side of the CPU memory stall interface.
//  Serves byte reads/writes after a fixed multi-cycle latency. Holds BUSYWAIT while an access is
//  in flight so the CPU (PC, register-file write-back) stalls until data is valid / stored.
// PARAMETERS
//  ADDR_WIDTH     8  address bits
//  DATA_WIDTH     8  data word bits
//  DEPTH        256  number of words (2**ADDR_WIDTH)
//  ACCESS_CYCLES  5  clock edges from accept to completion; legal range 1..15
// PORTS
//  CLK        in   1           rising-edge clock
//  RESET      in   1           asynchronous, active-low reset
//  READ       in   1           read request, level, held by CPU until BUSYWAIT drops
//  WRITE      in   1           write request, level, held by CPU until BUSYWAIT drops
//  ADDRESS    in   ADDR_WIDTH  word address
//  WRITEDATA  in   DATA_WIDTH  write data
//  READDATA   out  DATA_WIDTH  read data, registered
//  BUSYWAIT   out  1           stall to CPU
// BEHAVIOUR
//  Reset (RESET=0, async): state=IDLE, counter=0, READDATA=0, BUSYWAIT=0, all words cleared to 0.
//   Mid-access reset aborts the access: no write occurs, READDATA=0.
//  FSM states: IDLE, ACCESS, DONE.
//  IDLE: BUSYWAIT = READ|WRITE (combinational, same cycle as request).
//   On edge with READ|WRITE=1: latch op, ADDRESS, WRITEDATA; counter=ACCESS_CYCLES-1; ->ACCESS.
//   WRITE and READ both 1: treated as write; READ ignored, READDATA unchanged.
//  ACCESS: BUSYWAIT=1. Latched values used; input changes ignored. Counter decrements per edge.
//   Edge with counter==0: write -> mem[addr]<=data; read -> READDATA<=mem[addr]; ->DONE.
//   ACCESS_CYCLES=1: completion on the first edge after accept.
//  DONE: BUSYWAIT=0 for exactly one cycle; READ/WRITE ignored (CPU still drives the old request
//   while advancing). Next edge -> IDLE unconditionally.
//  Latency: accept edge T0, completion edge T0+ACCESS_CYCLES, BUSYWAIT low from completion edge,
//   new request accepted no earlier than edge T0+ACCESS_CYCLES+2.
//  Requests dropped in ACCESS do not cancel the access.
//  READDATA holds the last completed read value until the next read completes or reset.
//  Address is full-range; no wrap logic, DEPTH covers all ADDRESS values.
// TESTING
//  1 Reset: RESET=0 mid-sim -> READDATA=0, BUSYWAIT=0 immediately (no clock); read addr 8'h10 -> 0.
//  2 Write 8'hA5 to 8'h3C, then read 8'h3C -> BUSYWAIT high 6 cycles each (request cycle +
//    ACCESS_CYCLES), READDATA=8'hA5 after read completion edge, 1-cycle DONE gap between ops.
//  3 Change ADDRESS/WRITEDATA during ACCESS (8'h01/8'hFF) after accepting write 8'h02<-8'h11 ->
//    mem[8'h02]=8'h11, mem[8'h01] unchanged.
//  4 READ and WRITE both 1, addr 8'h07 data 8'h5A -> mem[8'h07]=8'h5A, READDATA unchanged.
//  5 Assert RESET at accept+2 edges of write 8'h20<-8'h77 -> BUSYWAIT=0 at once; later read of
//    8'h20 returns 8'h00.
//  6 Back-to-back: READ held through DONE cycle -> no second access; BUSYWAIT stays 0 in DONE;
//    new request one cycle later accepted normally.

Source files
------------

// File: rtl/data_memory_ctrl.sv
// rtl/data_memory_ctrl.sv - byte data memory with BUSYWAIT stall handshake
//
// Responder side of the CPU memory stall interface. A read or write request
// is accepted from IDLE, the operands are latched, and the access completes
// ACCESS_CYCLES edges later. BUSYWAIT stalls the CPU for the whole time.
// After completion a one-cycle DONE state lets the CPU advance while it still
// drives its old request, so that request is not taken a second time.
//
// Ports
//   CLK        in   rising-edge clock
//   RESET      in   asynchronous active-low reset; clears FSM, READDATA, memory
//   READ       in   read request, level, held until BUSYWAIT drops
//   WRITE      in   write request, level, held until BUSYWAIT drops (wins over READ)
//   ADDRESS    in   word address, ADDR_WIDTH bits
//   WRITEDATA  in   write data, DATA_WIDTH bits
//   READDATA   out  registered read data, holds the last completed read
//   BUSYWAIT   out  stall to CPU

module data_memory_ctrl #(
    parameter int ADDR_WIDTH    = 8,
    parameter int DATA_WIDTH    = 8,
    parameter int DEPTH         = 256,
    parameter int ACCESS_CYCLES = 5
) (
    input  logic                  CLK,
    input  logic                  RESET,
    input  logic                  READ,
    input  logic                  WRITE,
    input  logic [ADDR_WIDTH-1:0] ADDRESS,
    input  logic [DATA_WIDTH-1:0] WRITEDATA,
    output logic [DATA_WIDTH-1:0] READDATA,
    output logic                  BUSYWAIT
);

    // ACCESS_CYCLES is at most 15, so the preload value fits in four bits.
    localparam int                CNT_W    = 4;
    localparam logic [CNT_W-1:0]  CNT_INIT = CNT_W'(ACCESS_CYCLES - 1);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_DONE   = 2'd2
    } state_e;

    state_e                  state_q, state_d;
    logic [CNT_W-1:0]        cnt_q, cnt_d;
    logic                    op_write_q, op_write_d;
    logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
    logic [DATA_WIDTH-1:0]   wdata_q, wdata_d;
    logic [DATA_WIDTH-1:0]   rdata_q, rdata_d;
    logic [DATA_WIDTH-1:0]   mem_q [DEPTH];

    logic                    busy;
    logic                    complete;

    // ------------------------------------------------------------------
    // Next-state and output logic
    // ------------------------------------------------------------------
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        op_write_d = op_write_q;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        busy       = 1'b0;
        complete   = 1'b0;

        unique case (state_q)
            ST_IDLE: begin
                // Stall in the same cycle the request appears so the CPU
                // never advances past an unserved access.
                busy = READ | WRITE;
                if (READ || WRITE) begin
                    op_write_d = WRITE;
                    addr_d     = ADDRESS;
                    wdata_d    = WRITEDATA;
                    cnt_d      = CNT_INIT;
                    state_d    = ST_ACCESS;
                end
            end
            ST_ACCESS: begin
                busy = 1'b1;
                if (cnt_q == '0) begin
                    complete = 1'b1;
                    state_d  = ST_DONE;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            ST_DONE: begin
                // The CPU still drives its old request here; ignore it.
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Read data only changes when a read completes.
    always_comb begin
        rdata_d = rdata_q;
        if (complete && !op_write_q) begin
            rdata_d = mem_q[addr_q];
        end
    end

    // Gate with reset so a CPU still asserting its request while reset is
    // held does not see a stall.
    assign BUSYWAIT = busy & RESET;
    assign READDATA = rdata_q;

    // ------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------
    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            state_q    <= ST_IDLE;
            cnt_q      <= '0;
            op_write_q <= 1'b0;
            addr_q     <= '0;
            wdata_q    <= '0;
            rdata_q    <= '0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            op_write_q <= op_write_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
            rdata_q    <= rdata_d;
        end
    end

    // Storage array; a reset in the middle of an access aborts the write
    // because the completion strobe never fires.
    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else if (complete && op_write_q) begin
            mem_q[addr_q] <= wdata_q;
        end
    end

endmodule

// File: tb/tb_data_memory_ctrl.sv
// tb/tb_data_memory_ctrl.sv - self-checking bench for data_memory_ctrl
module tb_data_memory_ctrl;

    localparam int AC = 5;

    logic       CLK = 1'b0;
    logic       RESET;
    logic       READ;
    logic       WRITE;
    logic [7:0] ADDRESS;
    logic [7:0] WRITEDATA;
    logic [7:0] READDATA;
    logic       BUSYWAIT;

    int checks = 0;
    int errors = 0;

    // Reference model: plain byte array plus last read value.
    logic [7:0] ref_mem [256];
    logic [7:0] ref_rdata;

    data_memory_ctrl #(
        .ADDR_WIDTH   (8),
        .DATA_WIDTH   (8),
        .DEPTH        (256),
        .ACCESS_CYCLES(AC)
    ) dut (
        .CLK      (CLK),
        .RESET    (RESET),
        .READ     (READ),
        .WRITE    (WRITE),
        .ADDRESS  (ADDRESS),
        .WRITEDATA(WRITEDATA),
        .READDATA (READDATA),
        .BUSYWAIT (BUSYWAIT)
    );

    always #5 CLK = ~CLK;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 256; i++) ref_mem[i] = 8'h00;
        ref_rdata = 8'h00;
    endtask

    // Called at posedge+1 with the DUT idle. Returns at posedge+1, DUT idle.
    task automatic access(input bit wr, input bit rd, input logic [7:0] a,
                          input logic [7:0] d, input bit drop, input bit scramble,
                          input bit hold, input string tag);
        int  n;
        bit  done;
        WRITE     = wr;
        READ      = rd;
        ADDRESS   = a;
        WRITEDATA = d;
        #1;
        check({tag, " req_busy"}, BUSYWAIT, 1);
        if (wr)      ref_mem[a] = d;
        else if (rd) ref_rdata  = ref_mem[a];
        n    = 1;
        done = 0;
        for (int i = 0; i < 40 && !done; i++) begin
            @(posedge CLK); #1;
            if (i == 0) begin
                if (scramble) begin
                    ADDRESS   = a ^ 8'h03;
                    WRITEDATA = 8'hFF;
                end
                if (drop) begin
                    READ  = 1'b0;
                    WRITE = 1'b0;
                end
            end
            if (BUSYWAIT) n++;
            else          done = 1;
        end
        check({tag, " busy_cycles"}, n, AC + 1);
        check({tag, " readdata"}, READDATA, ref_rdata);
        if (!hold) begin
            READ  = 1'b0;
            WRITE = 1'b0;
        end
        @(posedge CLK); #1;
        check({tag, " idle_busy"}, BUSYWAIT, READ | WRITE);
    endtask

    initial begin
        bit         wr, rd, drop, scr, hold;
        int         op;
        logic [7:0] a, d;

        RESET = 1'b0; READ = 1'b0; WRITE = 1'b0; ADDRESS = '0; WRITEDATA = '0;
        model_reset();
        #1;
        check("por readdata", READDATA, 8'h00);
        check("por busy", BUSYWAIT, 1'b0);
        repeat (2) @(negedge CLK);
        RESET = 1'b1;
        @(posedge CLK); #1;

        // Write then read back, 1-cycle DONE gap between them.
        access(1, 0, 8'h3C, 8'hA5, 0, 0, 0, "wr3c");
        access(0, 1, 8'h3C, 8'h00, 0, 0, 0, "rd3c");
        check("rd3c value", READDATA, 8'hA5);

        // Reset mid-sim with READDATA nonzero and 8'h10 previously written.
        access(1, 0, 8'h10, 8'h33, 0, 0, 0, "wr10");
        #2 RESET = 1'b0;
        model_reset();
        #1;
        check("rst readdata", READDATA, 8'h00);
        check("rst busy", BUSYWAIT, 1'b0);
        @(negedge CLK); RESET = 1'b1;
        @(posedge CLK); #1;
        access(0, 1, 8'h10, 8'h00, 0, 0, 0, "rd10_after_rst");

        // Inputs change during ACCESS: latched operands must be used.
        access(1, 0, 8'h01, 8'h44, 0, 0, 0, "wr01");
        access(1, 0, 8'h02, 8'h11, 0, 1, 0, "wr02_scr");
        access(0, 1, 8'h02, 8'h00, 0, 0, 0, "rd02");
        check("rd02 value", READDATA, 8'h11);
        access(0, 1, 8'h01, 8'h00, 0, 0, 0, "rd01");
        check("rd01 value", READDATA, 8'h44);

        // READ and WRITE together: a write, READDATA unchanged.
        access(1, 1, 8'h07, 8'h5A, 0, 0, 0, "both07");
        check("both07 rdata kept", READDATA, 8'h44);
        access(0, 1, 8'h07, 8'h00, 0, 0, 0, "rd07");
        check("rd07 value", READDATA, 8'h5A);

        // Reset two edges after accepting a write aborts it.
        WRITE = 1'b1; ADDRESS = 8'h20; WRITEDATA = 8'h77;
        repeat (3) @(posedge CLK);
        #2 RESET = 1'b0;
        #1;
        check("abort busy", BUSYWAIT, 1'b0);
        check("abort readdata", READDATA, 8'h00);
        WRITE = 1'b0;
        model_reset();
        @(negedge CLK); RESET = 1'b1;
        @(posedge CLK); #1;
        access(0, 1, 8'h20, 8'h00, 0, 0, 0, "rd20_after_abort");
        check("rd20 value", READDATA, 8'h00);

        // Back-to-back: READ held through DONE, then re-accepted normally.
        access(1, 0, 8'h30, 8'hC3, 0, 0, 0, "wr30");
        access(0, 1, 8'h30, 8'h00, 0, 0, 1, "rd30_hold");
        access(0, 1, 8'h30, 8'h00, 0, 0, 0, "rd30_again");
        check("rd30 value", READDATA, 8'hC3);

        // Dropped request during ACCESS still completes.
        access(1, 0, 8'h31, 8'h9E, 1, 0, 0, "wr31_drop");
        access(0, 1, 8'h31, 8'h00, 1, 0, 0, "rd31_drop");
        check("rd31 value", READDATA, 8'h9E);

        // Randomized accesses over a small address window.
        for (int k = 0; k < 30; k++) begin
            op   = $urandom_range(0, 2);
            wr   = (op != 0);
            rd   = (op != 1);
            a    = 8'h80 + 8'($urandom_range(0, 7));
            d    = 8'($urandom);
            drop = ($urandom_range(0, 3) == 0);
            scr  = ($urandom_range(0, 3) == 0);
            hold = !drop && ($urandom_range(0, 2) == 0);
            access(wr, rd, a, d, drop, scr, hold, $sformatf("rnd%0d", k));
        end
        READ  = 1'b0;
        WRITE = 1'b0;
        @(posedge CLK); #1;
        check("end idle busy", BUSYWAIT, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
